// File: rtl/piece_pkg.sv
// Shared definitions for the 43-bit word assembler path and its piece buffer.
package piece_pkg;

   localparam int unsigned PIECE_W = 12;
   localparam int unsigned GROUP_N = 4;
   localparam int unsigned WORD_W  = 43;

   typedef logic [PIECE_W-1:0] piece_t;

endpackage

// File: rtl/piece_fifo_ctrl.sv
// Pointer, occupancy and group-position control for piece_fifo12.
// Flush and reset both clear all state; a pop is suppressed in either cycle.
module piece_fifo_ctrl
   import piece_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push_req,
   input  logic          pop_req,
   output logic          push,
   output logic          pop,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [AW:0]   count,
   output logic          full,
   output logic [1:0]    piece_idx
);

   localparam int unsigned CNT_W = AW + 1;

   logic empty;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // Full is judged on the current count only, so a pop in the same cycle
   // never makes room for a push.
   assign push = push_req && !full;
   assign pop  = pop_req && !empty && !flush && !rst;

   // Pointer, count and group-position update; flush outranks push/pop.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         piece_idx <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr    <= rd_ptr + AW'(1);
            piece_idx <= (piece_idx == 2'(GROUP_N - 1)) ? '0 : piece_idx + 2'd1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/piece_fifo12.sv
// Piece buffer feeding the 43-bit word assembler: valid/ready in,
// read_enable-gated write_enable/data_in out, group position tracking.
// Optional sticky overflow flag enabled by defining PIECE_FIFO_OVF_EN.
module piece_fifo12
   import piece_pkg::*;
#(
   parameter int unsigned DATA_W = PIECE_W,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   in_ready,
   input  logic                   dn_read_enable,
   output logic                   dn_write_enable,
   output logic [DATA_W-1:0]      dn_data,
   output logic [1:0]             piece_idx,
   output logic [$clog2(DEPTH):0] level,
   input  logic                   flush,
   output logic                   overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              push;
   logic              pop;
   logic              full;

   piece_fifo_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ctrl (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push_req  (in_valid),
      .pop_req   (dn_read_enable),
      .push      (push),
      .pop       (pop),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .count     (level),
      .full      (full),
      .piece_idx (piece_idx)
   );

   assign in_ready        = !full;
   assign dn_write_enable = pop;
   assign dn_data         = mem[rd_ptr];

   // Storage write; contents are never reset, the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

`ifdef PIECE_FIFO_OVF_EN
   // Sticky refused-push flag; survives flush, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (in_valid && !in_ready) begin
         overflow <= 1'b1;
      end
   end
`else
   assign overflow = 1'b0;
`endif

endmodule
